// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: operation/state types and operand sign rules for the multicycle multiplier
package mul_sequencer_pkg;
   typedef logic [31:0] i32;
   typedef logic [63:0] i64;
   typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_t;
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} mul_state_t;
   function automatic logic [1:0] op_signs(mul_op_t op, logic a_msb, logic b_msb);
      return {(op == MULH || op == MULHSU) && a_msb, op == MULH && b_msb};
   endfunction
endpackage

// File: rtl/mul_shift_add_core.sv
// mul_shift_add_core: unsigned WIDTH x WIDTH shift-add multiplier datapath, one add-and-shift per step
module mul_shift_add_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p
);
   logic [2*WIDTH:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH:0]   sum;
   always_comb sum = acc[0] ? acc[2*WIDTH:WIDTH] + {1'b0, mcand} : acc[2*WIDTH:WIDTH];
   always_ff @(posedge clk)
      if (reset) begin
         acc   <= '0;
         mcand <= '0;
      end else if (load) begin
         acc   <= {{(WIDTH + 1){1'b0}}, b};
         mcand <= a;
      end else if (step)
         acc <= {1'b0, sum, acc[WIDTH-1:1]};
   assign p = acc[2*WIDTH-1:0];
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: execute-stage MUL/MULH/MULHSU/MULHU sequencer; MUL_RESULT_CACHE_EN adds a one-entry result cache
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  mul_op_t          req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   mul_state_t         state, state_nx;
   mul_op_t            op;
   logic [WIDTH-1:0]   a, b, mag_a, mag_b;
   logic [CW-1:0]      cnt;
   logic [1:0]         sg;
   logic [2*WIDTH-1:0] p, prod, hit_p;
   logic               neg, accept, hit;

   assign sg         = op_signs(op, a[WIDTH-1], b[WIDTH-1]);
   assign mag_a      = sg[1] ? -a : a;
   assign mag_b      = sg[0] ? -b : b;
   assign prod       = neg ? -p : p;
   assign accept     = req_valid && state == IDLE && !flush;
   assign req_ready  = state == IDLE && !flush;
   assign resp_valid = state == DONE;
   assign busy       = state != IDLE;

   mul_shift_add_core #(.WIDTH(WIDTH)) core (
      .clk   (clk),
      .reset (reset),
      .load  (state == PREP),
      .step  (state == RUN),
      .a     (mag_a),
      .b     (mag_b),
      .p     (p)
   );

`ifdef MUL_RESULT_CACHE_EN
   logic             c_valid;
   logic [WIDTH-1:0] c_a, c_b;
   logic [1:0]       c_sg, req_sg;
   assign req_sg = op_signs(req_op, req_a[WIDTH-1], req_b[WIDTH-1]);
   // the low half is independent of operand signedness, so MUL hits on operands alone
   assign hit = c_valid && c_a == req_a && c_b == req_b && (req_op == MUL || req_sg == c_sg);
   always_ff @(posedge clk)
      if (reset) begin
         c_valid <= 1'b0;
         c_a     <= '0;
         c_b     <= '0;
         c_sg    <= '0;
         hit_p   <= '0;
      end else if (state == FIX && !flush) begin
         c_valid <= 1'b1;
         c_a     <= a;
         c_b     <= b;
         c_sg    <= sg;
         hit_p   <= prod;
      end
`else
   assign hit   = 1'b0;
   assign hit_p = '0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !accept ? IDLE : hit ? DONE : PREP;
         PREP:    state_nx = RUN;
         RUN:     state_nx = cnt == '0 ? FIX : RUN;
         FIX:     state_nx = DONE;
         DONE:    state_nx = resp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk)
      if (reset) begin
         state     <= IDLE;
         op        <= MUL;
         a         <= '0;
         b         <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         resp_data <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op <= req_op;
            a  <= req_a;
            b  <= req_b;
         end
         if (state == PREP) begin
            neg <= ^sg;
            cnt <= CW'(WIDTH - 1);
         end
         if (state == RUN) cnt <= cnt - 1'b1;
         if (state == FIX && !flush)
            resp_data <= op == MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
         else if (accept && hit)
            resp_data <= req_op == MUL ? hit_p[WIDTH-1:0] : hit_p[2*WIDTH-1:WIDTH];
      end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer with a signed-arithmetic reference model
module tb_mul_sequencer;
   import mul_sequencer_pkg::*;
`ifdef MUL_RESULT_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   localparam int MISS_LAT = 34;

   typedef struct {
      i32    data;
      int    t;
      int    lat;
      string name;
   } exp_t;

   logic    clk = 1'b0, reset = 1'b1, req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b0;
   logic    req_ready, resp_valid, busy;
   mul_op_t req_op = MUL;
   i32      req_a = '0, req_b = '0, resp_data;
   int      cyc = 0, passed = 0, total = 0, last_t = 0;
   bit      hold = 1'b0, held = 1'b0;
   i32      held_data;
   exp_t    q[$];
   exp_t    e;
   bit      cm_valid = 1'b0, sv_valid;
   i32      cm_a, cm_b, sv_a, sv_b;
   bit [1:0] cm_sg, sv_sg;

   mul_sequencer #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
   endtask

   function automatic bit [1:0] signs(mul_op_t op, i32 a, i32 b);
      return {(op == MULH || op == MULHSU) && a[31], op == MULH && b[31]};
   endfunction

   function automatic i32 ref_mul(mul_op_t op, i32 a, i32 b);
      i64 ea, eb, pr;
      ea = (op == MULH || op == MULHSU) ? i64'($signed(a)) : i64'(a);
      eb = (op == MULH) ? i64'($signed(b)) : i64'(b);
      pr = ea * eb;
      return op == MUL ? pr[31:0] : pr[63:32];
   endfunction

   function automatic i32 pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         3:       return i32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial forever begin
      @(negedge clk);
      resp_ready = !hold && $urandom_range(0, 3) != 0;
   end

   // monitor: latency on the first valid cycle, stability while stalled, data on handshake
   always @(negedge clk) begin
      #2;
      if (reset) held = 1'b0;
      else if (resp_valid) begin
         if (!held) begin
            if (q.size() == 0) check("unexpected_resp", 1, 0);
            else check({q[0].name, "_latency"}, 64'(cyc - q[0].t), 64'(q[0].lat));
         end else check("resp_data_stable", resp_data, held_data);
         if (resp_ready && q.size() != 0) begin
            e = q.pop_front();
            check(e.name, resp_data, e.data);
         end
         held      = !resp_ready;
         held_data = resp_data;
      end else held = 1'b0;
   end

   task automatic issue(input string name, input mul_op_t op, input i32 a, input i32 b, input i32 want);
      bit [1:0] sg;
      bit       hit;
      int       n;
      sg = signs(op, a, b);
      n  = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      #1;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         check({name, "_accept_timeout"}, 0, 1);
         req_valid = 1'b0;
         return;
      end
      hit      = CACHE && cm_valid && cm_a == a && cm_b == b && (op == MUL || cm_sg == sg);
      sv_valid = cm_valid;
      sv_a     = cm_a;
      sv_b     = cm_b;
      sv_sg    = cm_sg;
      if (!hit) begin
         cm_valid = 1'b1;
         cm_a     = a;
         cm_b     = b;
         cm_sg    = sg;
      end
      last_t = cyc + 1;
      q.push_back('{want, cyc + 1, hit ? 0 : MISS_LAT, name});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < 300) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (n >= 300) begin
         check("idle_timeout", 1, 0);
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int      nb, n;
      i32      a, b;
      mul_op_t op;
      repeat (3) @(negedge clk);
      #1;
      check("reset_req_ready", req_ready, 1);
      check("reset_resp_valid", resp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_resp_data", resp_data, 0);
      reset = 1'b0;

      issue("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      #1;
      nb = 0;
      n  = 0;
      while (!resp_valid && n < 100) begin
         if (busy) nb++;
         @(negedge clk);
         #1;
         n++;
      end
      check("busy_cycles_before_valid", 64'(nb), 64'(MISS_LAT));
      check("busy_with_valid", busy, 1);
      wait_idle();

      issue("mulh_min_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      wait_idle();
      issue("mulhu_max_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      wait_idle();
      issue("mulhsu_m1_max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle();
      issue("mulhsu_2_min", MULHSU, 32'd2, 32'h8000_0000, 32'h0000_0001);
      wait_idle();

      issue("flush_victim", MUL, 32'h0BAD_F00D, 32'h1234_5678, ref_mul(MUL, 32'h0BAD_F00D, 32'h1234_5678));
      while (cyc < last_t + 11) @(negedge clk);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = MUL;
      req_a     = 32'd3;
      req_b     = 32'd5;
      #1;
      check("flush_blocks_ready", req_ready, 0);
      check("busy_in_run", busy, 1);
      @(negedge clk);
      flush     = 1'b0;
      req_valid = 1'b0;
      #1;
      check("flush_busy", busy, 0);
      check("flush_resp_valid", resp_valid, 0);
      check("flush_ready_back", req_ready, 1);
      void'(q.pop_back());
      cm_valid = sv_valid;
      cm_a     = sv_a;
      cm_b     = sv_b;
      cm_sg    = sv_sg;
      repeat (5) @(negedge clk);
      issue("mul_3_5", MUL, 32'd3, 32'd5, 32'd15);
      wait_idle();

      hold = 1'b1;
      issue("hold_mulh", MULH, 32'hDEAD_BEEF, 32'h7654_3210, ref_mul(MULH, 32'hDEAD_BEEF, 32'h7654_3210));
      #1;
      n = 0;
      while (!resp_valid && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      repeat (5) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_op    = MULHU;
         req_a     = $urandom;
         req_b     = $urandom;
         #1;
         check("done_blocks_req", req_ready, 0);
         check("done_valid_held", resp_valid, 1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      hold      = 1'b0;
      wait_idle();

      issue("cache_mulh", MULH, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(MULH, 32'h1234_5678, 32'h9ABC_DEF0));
      wait_idle();
      issue("cache_mul", MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080);
      wait_idle();

      a = pick();
      b = pick();
      for (int i = 0; i < 30; i++) begin
         op = mul_op_t'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            a = pick();
            b = pick();
         end
         issue($sformatf("rand%0d", i), op, a, b, ref_mul(op, a, b));
         wait_idle();
      end

      issue("reset_victim", MULHU, 32'hCAFE_BABE, 32'h0F0F_F0F0, 32'h0);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      #1;
      check("midrun_reset_req_ready", req_ready, 1);
      check("midrun_reset_resp_valid", resp_valid, 0);
      check("midrun_reset_busy", busy, 0);
      check("midrun_reset_resp_data", resp_data, 0);
      reset    = 1'b0;
      cm_valid = 1'b0;
      issue("after_reset_mulhsu", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      wait_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
